// File: rtl/fmr_vote_ctrl_if.sv
// Replica-side and consumer-side signals of the five-replica vote controller.
// The master side drives start and the replica strobes; the slave side is the controller.
interface fmr_vote_ctrl_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [4:0]         rep_valid;
  logic [5*WIDTH-1:0] rep_data;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               busy;
  logic [4:0]         mask;
  logic [4:0]         mismatch;
  logic               fail;
  logic               tie;

  modport master (
    output start, rep_valid, rep_data,
    input  out_valid, out_data, busy, mask, mismatch, fail, tie
  );

  modport slave (
    input  start, rep_valid, rep_data,
    output out_valid, out_data, busy, mask, mismatch, fail, tie
  );
endinterface

// File: rtl/fmr_vote_ctrl.sv
// Five-replica majority voter with per-replica mismatch scoring and sticky masking.
// Optional FMR_LEAKY_SCORE_EN: clean rounds decay a replica's mismatch score by one.
module fmr_vote_ctrl #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 4,
  parameter int THRESH  = 3
) (
  input logic          clk,
  input logic          rst_n,
  fmr_vote_ctrl_if.slave bus
);

  localparam int               TMO_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, COLLECT, VOTE, REPORT} state_t;

  state_t           state, state_next;
  logic [TMO_W-1:0] tmo_cnt;
  logic [4:0]       got, capture, active;
  logic [WIDTH-1:0] cap_data [5];
  logic [CNT_W-1:0] score [5];
  logic [CNT_W-1:0] score_next [5];
  logic [4:0]       mask_next;
  logic [WIDTH-1:0] vote_data;
  logic             vote_tie;
  logic [4:0]       vote_mm;
  logic [WIDTH-1:0] out_data_q;
  logic [4:0]       mask_q, mismatch_q;
  logic             fail_q, tie_q;

  function automatic logic [2:0] popcount5(input logic [4:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < 5; i++) c = c + {2'b00, v[i]};
    return c;
  endfunction

  assign active  = ~mask_q;
  assign capture = (state == COLLECT) ? (bus.rep_valid & active & ~got) : 5'b0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Completion is judged on captures already registered, so the exit cycle can still capture
  // a last strobe that coincides with the timeout.
  // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = COLLECT;
      COLLECT: if (((got & active) == active) || (tmo_cnt <= TMO_W'(1))) state_next = VOTE;
      VOTE:    state_next = REPORT;
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the capture and score arrays are small flop arrays, cleared on reset so an aborted
  // round leaves no stale data behind; larger RAM-style storage would not be reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      got     <= '0;
      for (int i = 0; i < 5; i++) cap_data[i] <= '0;
    end else if (state == IDLE && bus.start) begin
      tmo_cnt <= TMO_W'(TIMEOUT);
      got     <= '0;
    end else if (state == COLLECT) begin
      if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - TMO_W'(1);
      got <= got | capture;
      for (int i = 0; i < 5; i++)
        if (capture[i]) cap_data[i] <= bus.rep_data[i*WIDTH +: WIDTH];
    end
  end

  // Bitwise majority over trusted replicas; a missing replica votes 0 and counts as a mismatch.
  always_comb begin
    logic [2:0] n;
    logic [2:0] ones;
    n         = popcount5(active);
    ones      = '0;
    vote_data = '0;
    vote_tie  = 1'b0;
    vote_mm   = '0;
    for (int b = 0; b < WIDTH; b++) begin
      ones = '0;
      for (int i = 0; i < 5; i++)
        if (active[i] && got[i] && cap_data[i][b]) ones = ones + 3'd1;
      if ({ones, 1'b0} >  {1'b0, n}) vote_data[b] = 1'b1;
      if ({ones, 1'b0} == {1'b0, n}) vote_tie     = 1'b1;
    end
    for (int i = 0; i < 5; i++)
      vote_mm[i] = active[i] && (!got[i] || (cap_data[i] != vote_data));
  end

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      score_next[i] = score[i];
      if (mismatch_q[i]) begin
        if (score[i] != CNT_MAX) score_next[i] = score[i] + CNT_W'(1);
      end
`ifdef FMR_LEAKY_SCORE_EN
      else if (active[i] && score[i] != '0) begin
        score_next[i] = score[i] - CNT_W'(1);
      end
`endif
      mask_next[i] = mask_q[i] | (score_next[i] >= CNT_W'(THRESH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= '0;
      mismatch_q <= '0;
      tie_q      <= 1'b0;
      mask_q     <= '0;
      fail_q     <= 1'b0;
      for (int i = 0; i < 5; i++) score[i] <= '0;
    end else if (state == VOTE) begin
      out_data_q <= vote_data;
      mismatch_q <= vote_mm;
      tie_q      <= vote_tie;
    end else if (state == REPORT) begin
      for (int i = 0; i < 5; i++) score[i] <= score_next[i];
      mask_q <= mask_next;
      if (popcount5(~mask_next) < 3'd3) fail_q <= 1'b1;
    end
  end

  assign bus.out_valid = (state == REPORT);
  assign bus.busy      = (state != IDLE);
  assign bus.out_data  = out_data_q;
  assign bus.mask      = mask_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.fail      = fail_q;
  assign bus.tie       = tie_q;

endmodule

// File: tb/tb_fmr_vote_ctrl.sv
// Self-checking bench for fmr_vote_ctrl: directed scenarios plus randomized rounds
// compared against a round-level model of voting, scoring and masking.
module tb_fmr_vote_ctrl;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;
  localparam int THRESH  = 3;
  localparam int SAT     = (1 << CNT_W) - 1;

  typedef struct packed {
    int               lat;
    logic [WIDTH-1:0] data;
    logic [4:0]       mm;
    logic             tie;
    logic [4:0]       mask;
    logic             fail;
    logic             ov_after;
    logic             busy_after;
  } round_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fmr_vote_ctrl_if #(.WIDTH(WIDTH)) bus ();

  fmr_vote_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .THRESH(THRESH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int               m_score [5];
  bit               m_mask [5];
  bit               m_fail;
  logic [WIDTH-1:0] rd_data [5];
  int               rd_cyc [5];
  bit               noise_en;
  round_t           obs_r, exp_r;

  function automatic string fmt(round_t r);
    return $sformatf("lat=%0d data=%h mm=%b tie=%b mask=%b fail=%b ov_after=%b busy_after=%b",
                     r.lat, r.data, r.mm, r.tie, r.mask, r.fail, r.ov_after, r.busy_after);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_score[i] = 0;
      m_mask[i]  = 0;
    end
    m_fail = 0;
  endtask

  // One full round at transaction level: vote, scoring, mask/fail update and expected latency.
  task automatic model_round(output round_t e);
    int n, ones, maxd, c, live;
    bit all_capt;
    bit capt [5];
    e = '0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      capt[i] = !m_mask[i] && rd_cyc[i] != 0;
      if (!m_mask[i]) n++;
    end
    for (int b = 0; b < WIDTH; b++) begin
      ones = 0;
      for (int i = 0; i < 5; i++) if (capt[i] && rd_data[i][b]) ones++;
      if (2 * ones > n)  e.data[b] = 1'b1;
      if (2 * ones == n) e.tie = 1'b1;
    end
    for (int i = 0; i < 5; i++)
      e.mm[i] = !m_mask[i] && (!capt[i] || rd_data[i] != e.data);
    all_capt = 1;
    maxd = 0;
    for (int i = 0; i < 5; i++)
      if (!m_mask[i]) begin
        if (rd_cyc[i] == 0) all_capt = 0;
        else if (rd_cyc[i] > maxd) maxd = rd_cyc[i];
      end
    if (!all_capt)     c = TIMEOUT;
    else if (maxd == 0) c = 1;
    else               c = (maxd + 1 > TIMEOUT) ? TIMEOUT : maxd + 1;
    e.lat = c + 2;
    for (int i = 0; i < 5; i++) begin
      if (e.mm[i]) begin
        if (m_score[i] < SAT) m_score[i]++;
      end
`ifdef FMR_LEAKY_SCORE_EN
      else if (!m_mask[i] && m_score[i] > 0) m_score[i]--;
`endif
      if (m_score[i] >= THRESH) m_mask[i] = 1;
    end
    live = 0;
    for (int i = 0; i < 5; i++) begin
      e.mask[i] = m_mask[i];
      if (!m_mask[i]) live++;
    end
    if (live < 3) m_fail = 1;
    e.fail = m_fail;
  endtask

  task automatic set_all(input logic [WIDTH-1:0] v, input int c);
    for (int i = 0; i < 5; i++) begin
      rd_data[i] = v;
      rd_cyc[i]  = c;
    end
  endtask

  task automatic drive_cycle(input int cyc);
    bus.rep_valid = '0;
    for (int i = 0; i < 5; i++) begin
      bus.rep_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      if (rd_cyc[i] == cyc) begin
        bus.rep_valid[i] = 1'b1;
        bus.rep_data[i*WIDTH +: WIDTH] = rd_data[i];
      end else if (noise_en && (m_mask[i] || (rd_cyc[i] != 0 && cyc > rd_cyc[i]))
                   && $urandom_range(2, 0) == 0) begin
        bus.rep_valid[i] = 1'b1;
      end
    end
  endtask

  // Drives one round and records what the DUT reports; must be called before model_round.
  task automatic run_round(output round_t o);
    bit done;
    o = '0;
    o.lat = -1;
    done = 0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.rep_valid = '0;
    for (int cyc = 1; cyc <= TIMEOUT + 8 && !done; cyc++) begin
      @(posedge clk); #1;
      bus.start = noise_en && cyc == 2 && $urandom_range(1, 0) == 1;
      drive_cycle(cyc);
      @(negedge clk);
      if (bus.out_valid) begin
        o.lat  = cyc;
        o.data = bus.out_data;
        o.mm   = bus.mismatch;
        o.tie  = bus.tie;
        done   = 1;
      end
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.rep_valid = '0;
    @(negedge clk);
    o.ov_after   = bus.out_valid;
    o.busy_after = bus.busy;
    o.mask       = bus.mask;
    o.fail       = bus.fail;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.rep_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.rep_valid = '0;
    bus.rep_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, bus.out_data, bus.busy, bus.mask, bus.mismatch, bus.fail, bus.tie} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: ov=%b data=%h busy=%b mask=%b mm=%b fail=%b tie=%b, want all 0",
               bus.out_valid, bus.out_data, bus.busy, bus.mask, bus.mismatch, bus.fail, bus.tie);
    end
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, bus.busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL idle_after_reset: ov=%b busy=%b, want 0 0", bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_unanimous();
    noise_en = 0;
    set_all(8'hA5, 1);
    run_round(obs_r);
    model_round(exp_r);
    n_cmp++;
    if (obs_r !== exp_r) begin
      n_bad++;
      $display("FAIL unanimous: got %s want %s", fmt(obs_r), fmt(exp_r));
    end
    n_cmp++;
    if (obs_r.lat !== 4 || obs_r.data !== 8'hA5 || obs_r.mm !== 5'b0 || obs_r.tie !== 1'b0
        || obs_r.mask !== 5'b0) begin
      n_bad++;
      $display("FAIL unanimous_plan: got %s want lat=4 data=a5 mm=0 tie=0 mask=0", fmt(obs_r));
    end
  endtask

  task automatic test_scoring();
    do_reset();
    noise_en = 0;
    set_all(8'hFF, 1);
    rd_data[2] = 8'h00;
    for (int r = 0; r < 4; r++) begin
      run_round(obs_r);
      model_round(exp_r);
      n_cmp++;
      if (obs_r !== exp_r) begin
        n_bad++;
        $display("FAIL scoring_round%0d: got %s want %s", r, fmt(obs_r), fmt(exp_r));
      end
      if (r == 2) begin
        n_cmp++;
        if (obs_r.mask !== 5'b00100 || obs_r.mm !== 5'b00100 || obs_r.data !== 8'hFF) begin
          n_bad++;
          $display("FAIL scoring_masked: got %s want mask=00100 mm=00100 data=ff", fmt(obs_r));
        end
      end
    end
    n_cmp++;
    if (obs_r.data !== 8'hFF || obs_r.tie !== 1'b0 || obs_r.mm !== 5'b0) begin
      n_bad++;
      $display("FAIL scoring_n4: got %s want data=ff tie=0 mm=0", fmt(obs_r));
    end
  endtask

  task automatic test_timeout();
    do_reset();
    noise_en = 0;
    rd_data[0] = 8'h3C; rd_cyc[0] = 1;
    rd_data[1] = 8'h3C; rd_cyc[1] = 3;
    rd_data[2] = 8'h3C; rd_cyc[2] = 5;
    rd_data[3] = 8'h7E; rd_cyc[3] = 2;
    rd_data[4] = 8'h3C; rd_cyc[4] = 0;
    run_round(obs_r);
    model_round(exp_r);
    n_cmp++;
    if (obs_r !== exp_r) begin
      n_bad++;
      $display("FAIL timeout_model: got %s want %s", fmt(obs_r), fmt(exp_r));
    end
    n_cmp++;
    if (obs_r.lat !== TIMEOUT + 2 || obs_r.data !== 8'h3C || obs_r.mm[4] !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_plan: got %s want lat=%0d data=3c mm[4]=1", fmt(obs_r), TIMEOUT + 2);
    end
    // last strobe arrives in the same cycle the timeout expires
    rd_cyc[4] = TIMEOUT;
    rd_data[3] = 8'h3C;
    run_round(obs_r);
    model_round(exp_r);
    n_cmp++;
    if (obs_r !== exp_r || obs_r.mm !== 5'b0 || obs_r.lat !== TIMEOUT + 2) begin
      n_bad++;
      $display("FAIL timeout_last_strobe: got %s want %s", fmt(obs_r), fmt(exp_r));
    end
  endtask

  task automatic test_fail();
    do_reset();
    noise_en = 0;
    set_all(8'hFF, 1);
    rd_data[0] = 8'h00;
    rd_data[1] = 8'h0F;
    for (int r = 0; r < 3; r++) begin
      run_round(obs_r);
      model_round(exp_r);
      n_cmp++;
      if (obs_r !== exp_r) begin
        n_bad++;
        $display("FAIL fail_phase1_round%0d: got %s want %s", r, fmt(obs_r), fmt(exp_r));
      end
    end
    n_cmp++;
    if (obs_r.mask !== 5'b00011 || obs_r.fail !== 1'b0) begin
      n_bad++;
      $display("FAIL fail_n3: got mask=%b fail=%b want mask=00011 fail=0", obs_r.mask, obs_r.fail);
    end
    rd_data[2] = 8'h00;
    for (int r = 0; r < 3; r++) begin
      run_round(obs_r);
      model_round(exp_r);
      n_cmp++;
      if (obs_r !== exp_r) begin
        n_bad++;
        $display("FAIL fail_phase2_round%0d: got %s want %s", r, fmt(obs_r), fmt(exp_r));
      end
    end
    n_cmp++;
    if (obs_r.mask !== 5'b00111 || obs_r.fail !== 1'b1) begin
      n_bad++;
      $display("FAIL fail_set: got mask=%b fail=%b want mask=00111 fail=1", obs_r.mask, obs_r.fail);
    end
    rd_data[3] = 8'hF0;
    run_round(obs_r);
    model_round(exp_r);
    n_cmp++;
    if (obs_r !== exp_r || obs_r.data !== 8'hF0 || obs_r.tie !== 1'b1) begin
      n_bad++;
      $display("FAIL fail_n2_tie: got %s want %s", fmt(obs_r), fmt(exp_r));
    end
    rd_cyc[3] = 0;
    rd_cyc[4] = 0;
    for (int r = 0; r < 4; r++) begin
      run_round(obs_r);
      model_round(exp_r);
      n_cmp++;
      if (obs_r !== exp_r) begin
        n_bad++;
        $display("FAIL fail_drain_round%0d: got %s want %s", r, fmt(obs_r), fmt(exp_r));
      end
    end
    n_cmp++;
    if (obs_r.data !== 8'h00 || obs_r.tie !== 1'b1 || obs_r.mask !== 5'b11111 || obs_r.fail !== 1'b1) begin
      n_bad++;
      $display("FAIL all_masked: got %s want data=00 tie=1 mask=11111 fail=1", fmt(obs_r));
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.out_data, bus.busy, bus.mask, bus.mismatch, bus.fail, bus.tie} !== '0) begin
      n_bad++;
      $display("FAIL reset_async: mask=%b fail=%b tie=%b busy=%b, want all 0",
               bus.mask, bus.fail, bus.tie, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    noise_en = 0;
    set_all(8'h3C, 1);
    rd_cyc[4] = 0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      drive_cycle(cyc);
    end
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_busy: busy=%b want 1", bus.busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.busy, bus.mismatch, bus.out_data} !== '0) begin
      n_bad++;
      $display("FAIL abort_outputs: ov=%b busy=%b mm=%b data=%h, want 0",
               bus.out_valid, bus.busy, bus.mismatch, bus.out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.rep_valid = '0;
    seen = 0;
    repeat (TIMEOUT + 6) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL abort_no_valid: out_valid or busy seen=1 after aborted round, want 0");
    end
    set_all(8'h5A, 2);
    rd_data[4] = 8'hA5;
    rd_cyc[4] = 1;
    run_round(obs_r);
    model_round(exp_r);
    n_cmp++;
    if (obs_r !== exp_r || obs_r.mask !== 5'b0 || obs_r.mm !== 5'b10000 || obs_r.data !== 8'h5A) begin
      n_bad++;
      $display("FAIL clean_after_abort: got %s want %s", fmt(obs_r), fmt(exp_r));
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] base;
    int sel;
    noise_en = 1;
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      for (int r = 0; r < 12; r++) begin
        base = WIDTH'($urandom);
        for (int i = 0; i < 5; i++) begin
          rd_data[i] = ($urandom_range(9, 0) < 7) ? base : WIDTH'($urandom);
          sel = $urandom_range(9, 0);
          if (sel < 8)       rd_cyc[i] = $urandom_range(4, 1);
          else if (sel == 8) rd_cyc[i] = $urandom_range(TIMEOUT, 1);
          else               rd_cyc[i] = 0;
        end
        run_round(obs_r);
        model_round(exp_r);
        n_cmp++;
        if (obs_r !== exp_r) begin
          n_bad++;
          $display("FAIL random_s%0d_r%0d: got %s want %s", seg, r, fmt(obs_r), fmt(exp_r));
        end
      end
    end
    noise_en = 0;
  endtask

`ifdef FMR_LEAKY_SCORE_EN
  task automatic test_leaky();
    do_reset();
    noise_en = 0;
    for (int r = 0; r < 6; r++) begin
      set_all(8'hC3, 1);
      if (r < 2 || r >= 4) rd_data[1] = 8'h3C;
      run_round(obs_r);
      model_round(exp_r);
      n_cmp++;
      if (obs_r !== exp_r) begin
        n_bad++;
        $display("FAIL leaky_round%0d: got %s want %s", r, fmt(obs_r), fmt(exp_r));
      end
    end
    n_cmp++;
    if (obs_r.mask[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL leaky_no_mask: mask=%b want mask[1]=0", obs_r.mask);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000 ns, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    noise_en = 0;
    set_all('0, 0);
    model_reset();
    test_reset();
    test_unanimous();
    test_scoring();
    test_timeout();
    test_fail();
    test_reset_mid();
    test_random();
`ifdef FMR_LEAKY_SCORE_EN
    test_leaky();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
